// File: rtl/pwm_3lfcc_modulator_if.sv
// -----------------------------------------------------------------------------
// pwm_3lfcc_modulator_if
// Bundles the setpoint/enable inputs and the gate/sync outputs of the
// three-level flying-capacitor modulator.
//   duty_i   : 16-bit duty setpoint (0 = 0 %, 65535 = full scale)
//   enable_i : run enable, low forces every switch off
//   s1_o/s4_o: leg A top/bottom gates
//   s2_o/s3_o: leg B top/bottom gates
//   sync_o   : one-cycle pulse in the last cycle of the leg A carrier
// master = setpoint/control side, slave = modulator.
// -----------------------------------------------------------------------------
interface pwm_3lfcc_modulator_if;
    logic [15:0] duty_i;
    logic        enable_i;
    logic        s1_o;
    logic        s2_o;
    logic        s3_o;
    logic        s4_o;
    logic        sync_o;

    modport master (
        output duty_i, enable_i,
        input  s1_o, s2_o, s3_o, s4_o, sync_o
    );

    modport slave (
        input  duty_i, enable_i,
        output s1_o, s2_o, s3_o, s4_o, sync_o
    );
endinterface

// File: rtl/pwm_3lfcc_modulator.sv
// -----------------------------------------------------------------------------
// pwm_3lfcc_modulator
// Phase-shifted PWM for a three-level flying-capacitor converter. Two carrier
// counters run 180 degrees apart; a single compare value (latched once per
// leg A period) is compared against both to give the raw leg demands. Each
// leg has its own dead-time FSM that drives a complementary top/bottom pair.
// Ports:
//   clk_i  : system clock
//   rst_ni : asynchronous active-low reset
//   bus    : pwm_3lfcc_modulator_if.slave (duty_i, enable_i in;
//            s1_o..s4_o, sync_o out)
// Parameters:
//   PERIOD_CYCLES : carrier period in clk_i cycles, even, 4..65535
//   DEAD_CYCLES   : dead time in clk_i cycles, 1..PERIOD_CYCLES/4
// -----------------------------------------------------------------------------

// -----------------------------------------------------------------------------
// pwm_3lfcc_leg
// Dead-time FSM for one complementary switch pair.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   enable        : run enable (low sends the leg to OFF on the next edge)
//   raw           : carrier compare demand (1 = top wanted, 0 = bottom)
//   top, bot      : registered gate drives, never high together
// -----------------------------------------------------------------------------
module pwm_3lfcc_leg #(
    parameter int DEAD_CYCLES = 27
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic enable,
    input  logic raw,
    output logic top,
    output logic bot
);
    typedef enum logic [1:0] {
        OFF    = 2'd0,
        TOP_ON = 2'd1,
        BOT_ON = 2'd2,
        DEAD   = 2'd3
    } legState_t;

    localparam logic [15:0] DEAD_LAST = 16'(DEAD_CYCLES);

    legState_t   state, stateNext;
    logic [15:0] deadCnt, deadCntNext;
    logic        topNext, botNext;

    // State register; gate outputs are registered alongside the state so
    // they change on the same edge.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state   <= OFF;
            deadCnt <= '0;
            top     <= 1'b0;
            bot     <= 1'b0;
        end else begin
            state   <= stateNext;
            deadCnt <= deadCntNext;
            top     <= topNext;
            bot     <= botNext;
        end
    end

    // Next-state logic. DEAD is entered with the counter at 1 and left when
    // it reaches DEAD_CYCLES, so the dead band always lasts the full
    // DEAD_CYCLES no matter how raw moves meanwhile.
    always_comb begin
        stateNext   = state;
        deadCntNext = deadCnt;
        if (!enable) begin
            stateNext   = OFF;
            deadCntNext = '0;
        end else begin
            unique case (state)
                OFF: begin
                    stateNext   = DEAD;
                    deadCntNext = 16'd1;
                end
                TOP_ON: begin
                    if (!raw) begin
                        stateNext   = DEAD;
                        deadCntNext = 16'd1;
                    end
                end
                BOT_ON: begin
                    if (raw) begin
                        stateNext   = DEAD;
                        deadCntNext = 16'd1;
                    end
                end
                DEAD: begin
                    if (deadCnt >= DEAD_LAST) begin
                        stateNext   = raw ? TOP_ON : BOT_ON;
                        deadCntNext = '0;
                    end else begin
                        deadCntNext = deadCnt + 16'd1;
                    end
                end
                default: begin
                    stateNext   = OFF;
                    deadCntNext = '0;
                end
            endcase
        end
    end

    // Output decode from the next state: only TOP_ON/BOT_ON drive a gate,
    // which makes top/bottom overlap impossible by construction.
    always_comb begin
        topNext = (stateNext == TOP_ON);
        botNext = (stateNext == BOT_ON);
    end
endmodule

module pwm_3lfcc_modulator #(
    parameter int PERIOD_CYCLES = 1350,
    parameter int DEAD_CYCLES   = 27
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    pwm_3lfcc_modulator_if.slave         bus
);
    localparam int          NUM_LEGS  = 2;
    localparam logic [15:0] CNT_LAST  = 16'(PERIOD_CYCLES - 1);
    localparam logic [15:0] CNT_PRE   = 16'(PERIOD_CYCLES - 2);
    localparam logic [15:0] CNT_HALF  = 16'(PERIOD_CYCLES / 2);
    localparam logic [31:0] PERIOD_32 = 32'(PERIOD_CYCLES);

    logic [15:0]          cntA, cntB;
    logic [15:0]          comp, compNext;
    logic                 syncQ;
    logic [NUM_LEGS-1:0]  raw, top, bot;

    // Full 32-bit product, upper half kept: duty 65535 still maps strictly
    // below PERIOD_CYCLES, so the top switch always gets a dead band.
    always_comb begin
        compNext = 16'((32'(bus.duty_i) * PERIOD_32) >> 16);
    end

    // Carriers run regardless of enable so the legs stay phase-locked.
    // cntB starts half a period ahead for the 180-degree shift. comp only
    // updates at the leg A wrap, so a duty change never splits a period.
    // sync is registered one count early so it is high exactly while
    // cntA == PERIOD_CYCLES-1 without a combinational output path.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cntA  <= '0;
            cntB  <= CNT_HALF;
            comp  <= '0;
            syncQ <= 1'b0;
        end else begin
            cntA  <= (cntA == CNT_LAST) ? '0 : cntA + 16'd1;
            cntB  <= (cntB == CNT_LAST) ? '0 : cntB + 16'd1;
            syncQ <= (cntA == CNT_PRE);
            if (cntA == CNT_LAST) begin
                comp <= compNext;
            end
        end
    end

    always_comb begin
        raw[0] = (cntA < comp);
        raw[1] = (cntB < comp);
    end

    // Leg 0 = A (s1/s4), leg 1 = B (s2/s3).
    for (genvar g = 0; g < NUM_LEGS; g++) begin : gLeg
        pwm_3lfcc_leg #(
            .DEAD_CYCLES (DEAD_CYCLES)
        ) uLeg (
            .clk_i  (clk_i),
            .rst_ni (rst_ni),
            .enable (bus.enable_i),
            .raw    (raw[g]),
            .top    (top[g]),
            .bot    (bot[g])
        );
    end

    assign bus.s1_o   = top[0];
    assign bus.s4_o   = bot[0];
    assign bus.s2_o   = top[1];
    assign bus.s3_o   = bot[1];
    assign bus.sync_o = syncQ;
endmodule

// File: tb/tb_pwm_3lfcc_modulator.sv
// -----------------------------------------------------------------------------
// tb_pwm_3lfcc_modulator
// Behavioural model (carrier arithmetic + per-leg countdown of the dead band)
// compared against the DUT on every negedge, plus literal expectations for
// the directed scenarios, then a randomized duty/enable run.
// -----------------------------------------------------------------------------
module tb_pwm_3lfcc_modulator;
    localparam int P = 20;
    localparam int D = 2;

    logic clk;
    logic rst_n;
    int   checks   = 0;
    int   failures = 0;

    pwm_3lfcc_modulator_if bus ();

    pwm_3lfcc_modulator #(
        .PERIOD_CYCLES (P),
        .DEAD_CYCLES   (D)
    ) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s at %0t: actual=%0d expected=%0d", name, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // side: 0 = nothing conducting, 1 = top, 2 = bottom.
    // rem : dead cycles still to go (0 = not in a dead band).
    typedef struct packed {
        logic [1:0]  side;
        logic [15:0] rem;
    } legM_t;

    int    mCntA;
    int    mComp;
    legM_t mLeg [2];

    function automatic legM_t stepLeg(input legM_t s, input logic en, input logic rawIn);
        legM_t n;
        n = s;
        if (!en) begin
            n.side = 2'd0;
            n.rem  = '0;
        end else if (s.rem != 0) begin
            n.rem = s.rem - 16'd1;
            if (n.rem == 0) n.side = rawIn ? 2'd1 : 2'd2;
        end else if (s.side == 2'd0) begin
            n.rem = 16'(D);
        end else if ((s.side == 2'd1 && !rawIn) || (s.side == 2'd2 && rawIn)) begin
            n.side = 2'd0;
            n.rem  = 16'(D);
        end
        return n;
    endfunction

    function automatic int cntBOf(input int a);
        return (a + P / 2) % P;
    endfunction

    function automatic int isTop(input legM_t s);
        return (s.side == 2'd1 && s.rem == 0) ? 1 : 0;
    endfunction

    function automatic int isBot(input legM_t s);
        return (s.side == 2'd2 && s.rem == 0) ? 1 : 0;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mCntA   <= 0;
            mComp   <= 0;
            mLeg[0] <= '0;
            mLeg[1] <= '0;
        end else begin
            mCntA <= (mCntA + 1) % P;
            if (mCntA == P - 1) mComp <= int'((longint'(bus.duty_i) * P) >> 16);
            mLeg[0] <= stepLeg(mLeg[0], bus.enable_i, mCntA < mComp);
            mLeg[1] <= stepLeg(mLeg[1], bus.enable_i, cntBOf(mCntA) < mComp);
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        chk("cmp_s1", int'(bus.s1_o), isTop(mLeg[0]));
        chk("cmp_s4", int'(bus.s4_o), isBot(mLeg[0]));
        chk("cmp_s2", int'(bus.s2_o), isTop(mLeg[1]));
        chk("cmp_s3", int'(bus.s3_o), isBot(mLeg[1]));
        chk("cmp_sync", int'(bus.sync_o), (mCntA == P - 1) ? 1 : 0);
        chk("overlap_A", int'(bus.s1_o & bus.s4_o), 0);
        chk("overlap_B", int'(bus.s2_o & bus.s3_o), 0);
    end

    // ---------------- directed helpers ----------------
    task automatic waitCnt(input int target);
        for (int i = 0; i < P + 2; i++) begin
            @(negedge clk);
            if (mCntA == target) return;
        end
        chk("waitCnt_timeout", mCntA, target);
    endtask

    task automatic measure(input int n, output int c1, output int c2,
                           output int c3, output int c4, output int gapA);
        c1 = 0; c2 = 0; c3 = 0; c4 = 0; gapA = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            c1 += int'(bus.s1_o);
            c2 += int'(bus.s2_o);
            c3 += int'(bus.s3_o);
            c4 += int'(bus.s4_o);
            if (!bus.s1_o && !bus.s4_o) gapA++;
        end
    endtask

    task automatic allGatesZero(input string name);
        chk(name, int'({bus.s1_o, bus.s2_o, bus.s3_o, bus.s4_o}), 0);
    endtask

    task automatic syncDistance(input string name);
        int k;
        k = 0;
        for (int i = 1; i <= 3 * P; i++) begin
            @(negedge clk);
            if (bus.sync_o) begin
                k = i;
                break;
            end
        end
        chk(name, k, P - 1);
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : stim
        int c1, c2, c3, c4, gap;
        int s1h [30];
        int s2h [30];
        int dly;

        rst_n        = 1'b0;
        bus.duty_i   = '0;
        bus.enable_i = 1'b0;

        // reset state
        repeat (3) @(negedge clk);
        allGatesZero("reset_gates");
        chk("reset_sync", int'(bus.sync_o), 0);
        #1;
        rst_n        = 1'b1;
        bus.duty_i   = 16'd32768;
        bus.enable_i = 1'b1;
        syncDistance("first_sync_after_reset");

        // 50 % steady state
        repeat (3 * P) @(negedge clk);
        waitCnt(P - 1);
        chk("comp_half", mComp, 10);
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            s1h[i] = int'(bus.s1_o);
            s2h[i] = int'(bus.s2_o);
        end
        c1 = 0; c4 = 0;
        for (int i = 0; i < P; i++) c1 += s1h[i];
        chk("half_s1_high", c1, 8);
        measure(P, c1, c2, c3, c4, gap);
        chk("half_s4_high", c4, 8);
        chk("half_gapA", gap, 4);
        chk("half_s1_high_b", c1, 8);
        dly = 0;
        for (int t = P / 2; t < 30; t++) if (s2h[t] != s1h[t - P / 2]) dly++;
        chk("half_s2_is_s1_delayed", dly, 0);

        // duty 0
        #1 bus.duty_i = 16'd0;
        repeat (2 * P) @(negedge clk);
        waitCnt(P - 1);
        chk("comp_zero", mComp, 0);
        measure(P, c1, c2, c3, c4, gap);
        chk("zero_s4", c4, P);
        chk("zero_s3", c3, P);
        chk("zero_s1", c1, 0);
        chk("zero_s2", c2, 0);

        // full scale
        #1 bus.duty_i = 16'hFFFF;
        repeat (3 * P) @(negedge clk);
        waitCnt(P - 1);
        chk("comp_full", mComp, 19);
        measure(P, c1, c2, c3, c4, gap);
        chk("full_s4", c4, 0);
        chk("full_s3", c3, 0);
        chk("full_s1_high", c1, P - 2);

        // mid-period duty step
        #1 bus.duty_i = 16'd32768;
        repeat (3 * P) @(negedge clk);
        waitCnt(5);
        #1 bus.duty_i = 16'd16384;
        waitCnt(P - 1);
        chk("step_comp_held", mComp, 10);
        chk("step_sync", int'(bus.sync_o), 1);
        @(negedge clk);
        chk("step_comp_new", mComp, 5);
        // this negedge is cntA==0 of the new period; count it plus 19 more
        c1 = int'(bus.s1_o); c4 = int'(bus.s4_o);
        measure(P - 1, c2, c3, gap, dly, gap);
        c1 += c2; c4 += dly;
        chk("step_s1_high", c1, 3);
        chk("step_s4_high", c4, 13);

        // enable drop / re-raise
        waitCnt(9);
        #1 bus.enable_i = 1'b0;
        @(negedge clk);
        allGatesZero("disable_gates");
        repeat (3) @(negedge clk);
        #1 bus.enable_i = 1'b1;
        @(negedge clk);
        allGatesZero("reenable_dead1");
        @(negedge clk);
        allGatesZero("reenable_dead2");
        @(negedge clk);
        chk("reenable_legA_on", int'(bus.s1_o | bus.s4_o), 1);
        chk("reenable_legB_on", int'(bus.s2_o | bus.s3_o), 1);

        // randomized duty / enable
        for (int i = 0; i < 800; i++) begin
            @(negedge clk);
            #1;
            if ($urandom_range(14, 0) == 0) begin
                case ($urandom_range(3, 0))
                    0:       bus.duty_i = 16'd0;
                    1:       bus.duty_i = 16'hFFFF;
                    default: bus.duty_i = 16'($urandom_range(65535, 0));
                endcase
            end
            if ($urandom_range(39, 0) == 0) bus.enable_i = ~bus.enable_i;
        end

        // asynchronous reset mid-period
        #1;
        bus.enable_i = 1'b1;
        bus.duty_i   = 16'd32768;
        repeat (4 * P) @(negedge clk);
        waitCnt(7);
        chk("pre_reset_s1_on", int'(bus.s1_o), 1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        allGatesZero("async_reset_gates");
        chk("async_reset_sync", int'(bus.sync_o), 0);
        @(negedge clk);
        allGatesZero("reset_hold_gates");
        #1 rst_n = 1'b1;
        syncDistance("sync_after_midreset");
        repeat (2 * P) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/pwm_3lfcc_modulator.md
PWM_3LFCC_MODULATOR -- requirements
Module: pwm_3lfcc_modulator

Interface
REQ-001 SHALL have parameter PERIOD_CYCLES, default 1350, carrier period in clk_i cycles (27 MHz / 20 kHz); even, range 4..65535.
REQ-002 SHALL have parameter DEAD_CYCLES, default 27, dead time in clk_i cycles; range 1..PERIOD_CYCLES/4.
REQ-003 SHALL have port clk_i, input, 1, system clock (27 MHz).
REQ-004 SHALL have port rst_ni, input, 1; one clock; reset is asynchronous and active-low.
REQ-005 SHALL have port duty_i, input, 16, duty setpoint from the UART setpoint stage; 0 = 0 %, 65535 = full scale.
REQ-006 SHALL have port enable_i, input, 1, modulator run enable; low forces all switches off.
REQ-007 SHALL have ports s1_o / s4_o, output, 1 each, leg A complementary gate pair (top / bottom).
REQ-008 SHALL have ports s2_o / s3_o, output, 1 each, leg B complementary gate pair (top / bottom).
REQ-009 SHALL have port sync_o, output, 1, one-cycle pulse marking leg A carrier wrap.

Function
REQ-010 SHALL run 16-bit carrier counter cnt_a counting 0..PERIOD_CYCLES-1, then wrapping to 0, every cycle, independent of enable_i.
REQ-011 SHALL run cnt_b identically but offset by PERIOD_CYCLES/2, giving a 180-degree phase shift.
REQ-012 SHALL compute comp = (duty_i * PERIOD_CYCLES) >> 16 using a full 32-bit product; result always < PERIOD_CYCLES.
REQ-013 SHALL load the comp register only on the edge where cnt_a wraps from PERIOD_CYCLES-1 to 0; duty_i changes mid-period have no effect until that wrap.
REQ-014 SHALL assert sync_o for exactly the cycle in which cnt_a == PERIOD_CYCLES-1.
REQ-015 SHALL derive raw_a = (cnt_a < comp) and raw_b = (cnt_b < comp), both using the single shared comp register.
REQ-016 SHALL give each leg an independent FSM with states OFF, TOP_ON, BOT_ON, DEAD, plus a dead-time counter.
REQ-017 SHALL decode outputs as: TOP_ON gives top=1, bottom=0; BOT_ON gives top=0, bottom=1; OFF and DEAD give both 0; the top and bottom of one leg SHALL never be high together.
REQ-018 SHALL register all gate outputs, updating on the same edge as the FSM state.
REQ-019 SHALL apply these transitions:
- TOP_ON with raw=0 goes to DEAD.
- BOT_ON with raw=1 goes to DEAD.
- On entry to DEAD, the dead-time counter loads 1.
- DEAD stays for exactly DEAD_CYCLES cycles, then goes to TOP_ON if raw=1 or BOT_ON if raw=0, sampled in the expiry cycle.
REQ-020 SHALL complete the full dead time even if raw toggles during DEAD; a raw pulse shorter than DEAD_CYCLES SHALL never turn on the opposite switch.
REQ-021 SHALL move both legs to OFF on the next edge whenever enable_i=0.
REQ-022 SHALL move each leg from OFF to DEAD on the first edge with enable_i=1, so all switches stay off for DEAD_CYCLES after enable.
REQ-023 SHALL turn the top switch on for comp-DEAD_CYCLES cycles and the bottom switch for PERIOD_CYCLES-comp-DEAD_CYCLES cycles per period in steady state, when both values are positive.
REQ-024 SHALL hold the bottom switch on continuously with duty_i=0 (comp=0), with no periodic dead-time gaps.

Reset
REQ-025 SHALL, while rst_ni=0, asynchronously force the following: s1_o..s4_o=0, sync_o=0, both FSMs OFF, cnt_a=0, cnt_b=PERIOD_CYCLES/2, comp=0, dead-time counters=0.
REQ-026 SHALL, on the first edge after rst_ni rises with enable_i=1, enter DEAD per REQ-022.
REQ-027 SHALL, when rst_ni is asserted mid-period, drive all gate outputs low within the same cycle without waiting for a clock edge.

Verification (PERIOD_CYCLES=20, DEAD_CYCLES=2)
REQ-028 SHALL cover: duty_i=32768, enable_i=1 steady state -> comp=10; s1_o high 8, low 12; s4_o high 8; two 2-cycle both-low gaps per period; s2_o equals s1_o delayed 10 cycles.
REQ-029 SHALL cover: duty_i=0 -> s4_o and s3_o constantly 1, s1_o and s2_o constantly 0 after the initial dead time.
REQ-030 SHALL cover: duty_i=65535 -> comp=19; s4_o and s3_o never 1; s1_o low exactly 2 cycles per period.
REQ-031 SHALL cover: duty_i stepped 32768 to 16384 at cnt_a=5 -> current period unchanged; comp=5 from the next wrap, coincident with the cycle after the sync_o pulse.
REQ-032 SHALL cover: enable_i dropped mid-period -> all gates 0 on the next edge; enable_i re-raised -> all gates 0 for 2 cycles, then resume per raw.
REQ-033 SHALL cover: rst_ni pulsed low mid-period -> all gates 0 immediately; cnt_a restarts from 0 and the REQ-025 values are checked; a top/bottom overlap assertion holds across the whole run.
